// File: rtl/ama_riscv_retire_trace.sv
// ---------------------------------------------------------------------------
// ama_riscv_retire_trace
//   Retirement trace and event counters for the writeback stage.
//   Every retired instruction pushes one record into a registered FIFO. The
//   FIFO is drained through a valid/ready stream. The performance counters
//   track retired instructions, branches, taken branches, predictor hits,
//   loads, stores, bubbles and dropped records. Back-pressure on the trace
//   stream never stalls counting. When the FIFO is full, a new record is
//   dropped and the sticky overflow flag is set.
//
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   inst_retired           instruction retired this cycle (push strobe)
//   inst_wbk, pc_wbk       retired instruction word / PC
//   branch_inst_wbk        retired instruction is a branch
//   branch_taken_wbk       branch was taken
//   bp_hit_wbk             branch predictor hit
//   bubble_wbk             writeback bubble (counted even without retire)
//   dmem_addr_wbk          data access address
//   dmem_size_wbk          0-3 load b/h/w/d, 4-7 store b/h/w/d, 8 none
//   cnt_clear              synchronous clear of counters and overflow
//   trc_valid / trc_ready  trace stream handshake
//   trc_pc, trc_inst,
//   trc_dmem_addr,
//   trc_dmem_size,
//   trc_flags              head record, flags = {bp_hit, taken, branch}
//   cnt_*                  event counters, CNT_W bits, wrap silently
//   overflow               sticky: at least one record was dropped
// ---------------------------------------------------------------------------
module ama_riscv_retire_trace #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inst_retired,
  input  logic [31:0]      inst_wbk,
  input  logic [31:0]      pc_wbk,
  input  logic             branch_inst_wbk,
  input  logic             branch_taken_wbk,
  input  logic             bp_hit_wbk,
  input  logic             bubble_wbk,
  input  logic [31:0]      dmem_addr_wbk,
  input  logic [3:0]       dmem_size_wbk,
  input  logic             cnt_clear,
  output logic             trc_valid,
  input  logic             trc_ready,
  output logic [31:0]      trc_pc,
  output logic [31:0]      trc_inst,
  output logic [31:0]      trc_dmem_addr,
  output logic [3:0]       trc_dmem_size,
  output logic [2:0]       trc_flags,
  output logic [CNT_W-1:0] cnt_retired,
  output logic [CNT_W-1:0] cnt_branch,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_bp_hit,
  output logic [CNT_W-1:0] cnt_load,
  output logic [CNT_W-1:0] cnt_store,
  output logic [CNT_W-1:0] cnt_bubble,
  output logic [CNT_W-1:0] cnt_dropped,
  output logic             overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  // -------------------------------------------------------------------------
  // Trace FIFO storage (data RAM is not reset; the head outputs are gated
  // to zero while the FIFO is empty, which covers the reset state)
  // -------------------------------------------------------------------------
  logic [31:0] r_pc_mem   [DEPTH];
  logic [31:0] r_inst_mem [DEPTH];
  logic [31:0] r_addr_mem [DEPTH];
  logic [3:0]  r_size_mem [DEPTH];
  logic [2:0]  r_flag_mem [DEPTH];

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_CNT);

  // Pop only when something is queued; this also makes trc_ready a no-op
  // in a cycle where an empty FIFO receives its first push.
  assign w_pop  = !w_empty && trc_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_push = inst_retired && (!w_full || w_pop);
  assign w_drop = inst_retired && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wptr]   <= pc_wbk;
      r_inst_mem[r_wptr] <= inst_wbk;
      r_addr_mem[r_wptr] <= dmem_addr_wbk;
      r_size_mem[r_wptr] <= dmem_size_wbk;
      r_flag_mem[r_wptr] <= {bp_hit_wbk, branch_taken_wbk, branch_inst_wbk};
    end
  end

  // Pointers are AW bits wide and DEPTH is a power of two, so the natural
  // binary rollover implements the modulo-DEPTH wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head record straight from storage: stable while stalled because neither
  // r_rptr nor the head slot changes without a pop (a push never targets the
  // head slot while the FIFO is non-empty and not popping).
  always_comb begin
    trc_valid     = !w_empty;
    trc_pc        = '0;
    trc_inst      = '0;
    trc_dmem_addr = '0;
    trc_dmem_size = '0;
    trc_flags     = '0;
    if (!w_empty) begin
      trc_pc        = r_pc_mem[r_rptr];
      trc_inst      = r_inst_mem[r_rptr];
      trc_dmem_addr = r_addr_mem[r_rptr];
      trc_dmem_size = r_size_mem[r_rptr];
      trc_flags     = r_flag_mem[r_rptr];
    end
  end

  // -------------------------------------------------------------------------
  // Event counters
  // -------------------------------------------------------------------------
  logic w_ev_branch;
  logic w_ev_taken;
  logic w_ev_bp_hit;
  logic w_ev_load;
  logic w_ev_store;

  assign w_ev_branch = inst_retired && branch_inst_wbk;
  assign w_ev_taken  = inst_retired && branch_taken_wbk;
  assign w_ev_bp_hit = inst_retired && bp_hit_wbk;
  assign w_ev_load   = inst_retired && (dmem_size_wbk < 4'd4);
  assign w_ev_store  = inst_retired && (dmem_size_wbk[3:2] == 2'b01);

  logic [CNT_W-1:0] r_cnt_retired;
  logic [CNT_W-1:0] r_cnt_branch;
  logic [CNT_W-1:0] r_cnt_taken;
  logic [CNT_W-1:0] r_cnt_bp_hit;
  logic [CNT_W-1:0] r_cnt_load;
  logic [CNT_W-1:0] r_cnt_store;
  logic [CNT_W-1:0] r_cnt_bubble;
  logic [CNT_W-1:0] r_cnt_dropped;
  logic             r_overflow;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_retired <= '0;
      r_cnt_branch  <= '0;
      r_cnt_taken   <= '0;
      r_cnt_bp_hit  <= '0;
      r_cnt_load    <= '0;
      r_cnt_store   <= '0;
      r_cnt_bubble  <= '0;
      r_cnt_dropped <= '0;
      r_overflow    <= 1'b0;
    end else if (cnt_clear) begin
      r_cnt_retired <= '0;
      r_cnt_branch  <= '0;
      r_cnt_taken   <= '0;
      r_cnt_bp_hit  <= '0;
      r_cnt_load    <= '0;
      r_cnt_store   <= '0;
      r_cnt_bubble  <= '0;
      r_cnt_dropped <= '0;
      r_overflow    <= 1'b0;
    end else begin
      r_cnt_retired <= r_cnt_retired + CNT_W'(inst_retired);
      r_cnt_branch  <= r_cnt_branch  + CNT_W'(w_ev_branch);
      r_cnt_taken   <= r_cnt_taken   + CNT_W'(w_ev_taken);
      r_cnt_bp_hit  <= r_cnt_bp_hit  + CNT_W'(w_ev_bp_hit);
      r_cnt_load    <= r_cnt_load    + CNT_W'(w_ev_load);
      r_cnt_store   <= r_cnt_store   + CNT_W'(w_ev_store);
      r_cnt_bubble  <= r_cnt_bubble  + CNT_W'(bubble_wbk);
      r_cnt_dropped <= r_cnt_dropped + CNT_W'(w_drop);
      r_overflow    <= r_overflow | w_drop;
    end
  end

  assign cnt_retired = r_cnt_retired;
  assign cnt_branch  = r_cnt_branch;
  assign cnt_taken   = r_cnt_taken;
  assign cnt_bp_hit  = r_cnt_bp_hit;
  assign cnt_load    = r_cnt_load;
  assign cnt_store   = r_cnt_store;
  assign cnt_bubble  = r_cnt_bubble;
  assign cnt_dropped = r_cnt_dropped;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_ama_riscv_retire_trace.sv
// ---------------------------------------------------------------------------
// tb_ama_riscv_retire_trace
//   Self-checking bench for ama_riscv_retire_trace (DEPTH=8, CNT_W=8 so that
//   counter wrap is reachable). A queue-based reference model is advanced on
//   every rising edge and all outputs are compared #1 after the edge.
// ---------------------------------------------------------------------------
module tb_ama_riscv_retire_trace;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CNT_W = 8;
  localparam int unsigned CMOD  = 1 << CNT_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             inst_retired;
  logic [31:0]      inst_wbk;
  logic [31:0]      pc_wbk;
  logic             branch_inst_wbk;
  logic             branch_taken_wbk;
  logic             bp_hit_wbk;
  logic             bubble_wbk;
  logic [31:0]      dmem_addr_wbk;
  logic [3:0]       dmem_size_wbk;
  logic             cnt_clear;
  logic             trc_valid;
  logic             trc_ready;
  logic [31:0]      trc_pc;
  logic [31:0]      trc_inst;
  logic [31:0]      trc_dmem_addr;
  logic [3:0]       trc_dmem_size;
  logic [2:0]       trc_flags;
  logic [CNT_W-1:0] cnt_retired;
  logic [CNT_W-1:0] cnt_branch;
  logic [CNT_W-1:0] cnt_taken;
  logic [CNT_W-1:0] cnt_bp_hit;
  logic [CNT_W-1:0] cnt_load;
  logic [CNT_W-1:0] cnt_store;
  logic [CNT_W-1:0] cnt_bubble;
  logic [CNT_W-1:0] cnt_dropped;
  logic             overflow;

  ama_riscv_retire_trace #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .inst_retired     (inst_retired),
    .inst_wbk         (inst_wbk),
    .pc_wbk           (pc_wbk),
    .branch_inst_wbk  (branch_inst_wbk),
    .branch_taken_wbk (branch_taken_wbk),
    .bp_hit_wbk       (bp_hit_wbk),
    .bubble_wbk       (bubble_wbk),
    .dmem_addr_wbk    (dmem_addr_wbk),
    .dmem_size_wbk    (dmem_size_wbk),
    .cnt_clear        (cnt_clear),
    .trc_valid        (trc_valid),
    .trc_ready        (trc_ready),
    .trc_pc           (trc_pc),
    .trc_inst         (trc_inst),
    .trc_dmem_addr    (trc_dmem_addr),
    .trc_dmem_size    (trc_dmem_size),
    .trc_flags        (trc_flags),
    .cnt_retired      (cnt_retired),
    .cnt_branch       (cnt_branch),
    .cnt_taken        (cnt_taken),
    .cnt_bp_hit       (cnt_bp_hit),
    .cnt_load         (cnt_load),
    .cnt_store        (cnt_store),
    .cnt_bubble       (cnt_bubble),
    .cnt_dropped      (cnt_dropped),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model: a queue of records plus integer counters
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [31:0] addr;
    logic [3:0]  size;
    logic [2:0]  flags;
  } rec_t;

  rec_t        mq[$];
  int unsigned m_ret, m_br, m_tk, m_bp, m_ld, m_st, m_bub, m_drop;
  bit          m_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic model_reset();
    mq.delete();
    m_ret = 0; m_br = 0; m_tk = 0; m_bp = 0;
    m_ld = 0; m_st = 0; m_bub = 0; m_drop = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_edge();
    int unsigned sz;
    bit          pop;
    bit          drop;
    rec_t        r;
    if (rst) begin
      model_reset();
      return;
    end
    sz   = mq.size();
    pop  = (sz > 0) && trc_ready;
    drop = 1'b0;
    if (pop) void'(mq.pop_front());
    if (inst_retired) begin
      r.pc    = pc_wbk;
      r.inst  = inst_wbk;
      r.addr  = dmem_addr_wbk;
      r.size  = dmem_size_wbk;
      r.flags = {bp_hit_wbk, branch_taken_wbk, branch_inst_wbk};
      if (sz < DEPTH || pop) mq.push_back(r);
      else                   drop = 1'b1;
    end
    if (cnt_clear) begin
      m_ret = 0; m_br = 0; m_tk = 0; m_bp = 0;
      m_ld = 0; m_st = 0; m_bub = 0; m_drop = 0;
      m_ovf = 1'b0;
    end else begin
      if (inst_retired) begin
        m_ret = (m_ret + 1) % CMOD;
        if (branch_inst_wbk)  m_br = (m_br + 1) % CMOD;
        if (branch_taken_wbk) m_tk = (m_tk + 1) % CMOD;
        if (bp_hit_wbk)       m_bp = (m_bp + 1) % CMOD;
        if (dmem_size_wbk < 4)                          m_ld = (m_ld + 1) % CMOD;
        if (dmem_size_wbk >= 4 && dmem_size_wbk <= 7)   m_st = (m_st + 1) % CMOD;
      end
      if (bubble_wbk) m_bub = (m_bub + 1) % CMOD;
      if (drop) begin
        m_drop = (m_drop + 1) % CMOD;
        m_ovf  = 1'b1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    rec_t h;
    h = '0;
    if (mq.size() > 0) h = mq[0];
    chk("trc_valid",     32'(trc_valid),     32'(mq.size() > 0));
    chk("trc_pc",        trc_pc,             h.pc);
    chk("trc_inst",      trc_inst,           h.inst);
    chk("trc_dmem_addr", trc_dmem_addr,      h.addr);
    chk("trc_dmem_size", 32'(trc_dmem_size), 32'(h.size));
    chk("trc_flags",     32'(trc_flags),     32'(h.flags));
    chk("cnt_retired",   32'(cnt_retired),   m_ret);
    chk("cnt_branch",    32'(cnt_branch),    m_br);
    chk("cnt_taken",     32'(cnt_taken),     m_tk);
    chk("cnt_bp_hit",    32'(cnt_bp_hit),    m_bp);
    chk("cnt_load",      32'(cnt_load),      m_ld);
    chk("cnt_store",     32'(cnt_store),     m_st);
    chk("cnt_bubble",    32'(cnt_bubble),    m_bub);
    chk("cnt_dropped",   32'(cnt_dropped),   m_drop);
    chk("overflow",      32'(overflow),      32'(m_ovf));
  endtask

  // One clock: inputs are already driven; advance model at the edge, compare #1 later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    inst_retired = 0; branch_inst_wbk = 0; branch_taken_wbk = 0; bp_hit_wbk = 0;
    bubble_wbk = 0; cnt_clear = 0; inst_wbk = '0; pc_wbk = '0;
    dmem_addr_wbk = '0; dmem_size_wbk = 4'd8;
  endtask

  task automatic rand_rec();
    pc_wbk           = $urandom & 32'hFFFF_FFFC;
    inst_wbk         = $urandom;
    dmem_addr_wbk    = $urandom;
    dmem_size_wbk    = 4'($urandom_range(15));
    branch_inst_wbk  = 1'($urandom);
    branch_taken_wbk = 1'($urandom);
    bp_hit_wbk       = 1'($urandom);
  endtask

  logic [31:0] first_pc;
  logic [31:0] new_pc;

  initial begin
    rst = 1'b1;
    trc_ready = 1'b0;
    idle_inputs();
    model_reset();
    repeat (2) cyc();
    rst = 1'b0;
    cyc();

    // Single record, immediate drain
    inst_retired = 1; pc_wbk = 32'h100; inst_wbk = 32'h0000_0013;
    dmem_size_wbk = 4'd8; trc_ready = 1;
    cyc();
    chk("r032_valid", 32'(trc_valid), 32'd1);
    chk("r032_pc",    trc_pc,         32'h100);
    inst_retired = 0;
    cyc();
    chk("r032_popped",  32'(trc_valid),   32'd0);
    chk("r032_retired", 32'(cnt_retired), 32'd1);
    chk("r032_loadst",  32'(cnt_load) + 32'(cnt_store), 32'd0);

    // Fill past capacity with back-pressure
    trc_ready = 0;
    for (int i = 0; i < 9; i++) begin
      inst_retired = 1; rand_rec();
      if (i == 0) first_pc = pc_wbk;
      cyc();
    end
    inst_retired = 0;
    chk("r033_overflow", 32'(overflow),    32'd1);
    chk("r033_dropped",  32'(cnt_dropped), 32'd1);
    chk("r033_head_pc",  trc_pc,           first_pc);

    // Full with push and pop together
    trc_ready = 1; inst_retired = 1; rand_rec(); new_pc = pc_wbk;
    cyc();
    inst_retired = 0;
    chk("r034_dropped", 32'(cnt_dropped), 32'd1);
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) chk("r034_tail_pc", trc_pc, new_pc);
      cyc();
    end
    chk("r034_drained", 32'(trc_valid), 32'd0);

    // Per-event counters
    cnt_clear = 1; cyc(); cnt_clear = 0;
    inst_retired = 1; rand_rec();
    branch_inst_wbk = 1; branch_taken_wbk = 1; bp_hit_wbk = 1; dmem_size_wbk = 4'd8;
    cyc();
    branch_inst_wbk = 0; branch_taken_wbk = 0; bp_hit_wbk = 0; dmem_size_wbk = 4'd2;
    cyc();
    dmem_size_wbk = 4'd5;
    cyc();
    inst_retired = 0; bubble_wbk = 1;
    repeat (2) cyc();
    bubble_wbk = 0;
    chk("r035_branch", 32'(cnt_branch), 32'd1);
    chk("r035_taken",  32'(cnt_taken),  32'd1);
    chk("r035_bp_hit", 32'(cnt_bp_hit), 32'd1);
    chk("r035_load",   32'(cnt_load),   32'd1);
    chk("r035_store",  32'(cnt_store),  32'd1);
    chk("r035_bubble", 32'(cnt_bubble), 32'd2);

    // Counter wrap, then clear beating a same-cycle retire
    cnt_clear = 1; cyc(); cnt_clear = 0;
    trc_ready = 1;
    for (int i = 0; i < CMOD - 1; i++) begin
      inst_retired = 1; rand_rec(); cyc();
    end
    chk("r036_max", 32'(cnt_retired), CMOD - 1);
    rand_rec(); cyc();
    chk("r036_wrap", 32'(cnt_retired), 32'd0);
    trc_ready = 0;
    for (int i = 0; i < DEPTH + 2; i++) begin rand_rec(); cyc(); end
    chk("r036_ovf_set", 32'(overflow), 32'd1);
    rand_rec(); dmem_size_wbk = 4'd2; bubble_wbk = 1; cnt_clear = 1;
    cyc();
    cnt_clear = 0; bubble_wbk = 0; inst_retired = 0;
    chk("r036_clr_retired", 32'(cnt_retired), 32'd0);
    chk("r036_clr_load",    32'(cnt_load),    32'd0);
    chk("r036_clr_bubble",  32'(cnt_bubble),  32'd0);
    chk("r036_clr_ovf",     32'(overflow),    32'd0);
    chk("r036_fifo_kept",   32'(trc_valid),   32'd1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      inst_retired = ($urandom_range(9) < 7);
      rand_rec();
      bubble_wbk = ($urandom_range(3) == 0);
      trc_ready  = ($urandom_range(9) < 6);
      cnt_clear  = ($urandom_range(31) == 0);
      cyc();
    end
    idle_inputs();

    // Asynchronous reset with queued records
    trc_ready = 1; repeat (DEPTH + 1) cyc();
    trc_ready = 0;
    for (int i = 0; i < 5; i++) begin inst_retired = 1; rand_rec(); cyc(); end
    inst_retired = 0;
    chk("r037_pre_valid", 32'(trc_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("r037_valid_now", 32'(trc_valid), 32'd0);
    cyc();
    rst = 1'b0;
    inst_retired = 1; rand_rec(); first_pc = pc_wbk;
    cyc();
    inst_retired = 0;
    chk("r037_one_valid", 32'(trc_valid), 32'd1);
    chk("r037_one_pc",    trc_pc,         first_pc);
    trc_ready = 1;
    cyc();
    chk("r037_single", 32'(trc_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ama_riscv_retire_trace.md
AMA_RISCV_RETIRE_TRACE -- requirements
Module: ama_riscv_retire_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 8, trace FIFO entries (power of 2, >=2).
REQ-002 SHALL have parameter CNT_W, default 32, event counter width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port inst_retired  input  1  writeback-stage instruction retired this cycle.
REQ-006 SHALL have port inst_wbk  input  32  retired instruction word.
REQ-007 SHALL have port pc_wbk  input  32  retired PC.
REQ-008 SHALL have ports branch_inst_wbk, branch_taken_wbk, bp_hit_wbk, bubble_wbk  input  1 each  writeback-stage branch, taken, predictor-hit and bubble flags.
REQ-009 SHALL have port dmem_addr_wbk  input  32  data access address.
REQ-010 SHALL have port dmem_size_wbk  input  4  0-3 lb/lh/lw/ld, 4-7 sb/sh/sw/sd, 8 no access.
REQ-011 SHALL have port cnt_clear  input  1  synchronous clear of all counters and overflow.
REQ-012 SHALL have ports trc_valid output 1, trc_ready input 1  trace record stream handshake.
REQ-013 SHALL have ports trc_pc output 32, trc_inst output 32, trc_dmem_addr output 32, trc_dmem_size output 4, trc_flags output 3 {bp_hit, taken, branch}  head record fields.
REQ-014 SHALL have ports cnt_retired, cnt_branch, cnt_taken, cnt_bp_hit, cnt_load, cnt_store, cnt_bubble, cnt_dropped  output  CNT_W each  event counters.
REQ-015 SHALL have port overflow  output  1  sticky: a record was dropped.

Function
REQ-016 SHALL push one record {pc, inst, dmem_addr, dmem_size, flags} per cycle with inst_retired=1.
REQ-017 SHALL pop head when trc_valid && trc_ready; trc_valid = FIFO non-empty.
REQ-018 SHALL present a record pushed at edge N at the head no earlier than after edge N (registered FIFO, 1-cycle min latency, no fall-through).
REQ-019 SHALL hold trc_* fields stable while trc_valid=1 and trc_ready=0.
REQ-020 SHALL, when full with push and no pop: drop the new record, set overflow, increment cnt_dropped; FIFO content unchanged.
REQ-021 SHALL, when full with simultaneous push and pop: accept push, count stays DEPTH, no drop.
REQ-022 SHALL, when empty with push: ignore trc_ready that cycle (nothing to pop); count becomes 1.
REQ-023 SHALL wrap read/write pointers modulo DEPTH; count range 0..DEPTH.
REQ-024 SHALL, on inst_retired=1, increment cnt_retired; cnt_branch if branch_inst_wbk; cnt_taken if branch_taken_wbk; cnt_bp_hit if bp_hit_wbk; cnt_load if size<4; cnt_store if 4<=size<=7.
REQ-025 SHALL increment cnt_bubble on bubble_wbk=1 regardless of inst_retired.
REQ-026 SHALL update counters and FIFO independently of trc_ready (trace back-pressure never stalls counting).
REQ-027 SHALL wrap counters 2^CNT_W-1 -> 0 silently.
REQ-028 SHALL give cnt_clear priority over same-cycle increments (counters=0, overflow=0); FIFO unaffected.
REQ-029 SHALL ignore all record/flag inputs when inst_retired=0 (except bubble_wbk).

Reset
REQ-030 SHALL on rst=1 immediately clear FIFO (count 0, pointers 0), trc_valid=0, overflow=0, all counters 0; trc_* data fields 0.
REQ-031 SHALL, on reset mid-stream, discard all queued records; first record after deassertion behaves as from empty.

Verification
REQ-032 Push pc=0x100, inst=0x00000013, size=8, ready=1 -> trc_valid next cycle with those fields, popped, cnt_retired=1, cnt_load=cnt_store=0.
REQ-033 ready=0, 9 back-to-back retires (DEPTH=8) -> count 8, overflow=1, cnt_dropped=1, head pc is first pushed.
REQ-034 Full, push+pop same cycle -> no drop, popped record = oldest, new record appended at tail.
REQ-035 Retires with branch=1,taken=1,bp_hit=1 then size=2 then size=5, plus 2 bubble cycles -> cnt_branch=1, cnt_taken=1, cnt_bp_hit=1, cnt_load=1, cnt_store=1, cnt_bubble=2.
REQ-036 cnt_retired forced near 2^CNT_W-1 then retire, and cnt_clear with simultaneous retire -> wrap to 0; clear wins, counters 0.
REQ-037 rst asserted with 5 queued records -> trc_valid=0 immediately, all counters 0, next push yields single valid record.
